mem_port_arbiter: RTL and testbench

//  Shares the single memory read/write port between instruction fetch (IF) and load/store (LS).

---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Load/store has priority; a starvation counter and a response watchdog back it up.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_if_addr_valid,
   input  logic [ADDR_W-1:0] i_if_addr,
   output logic              o_if_mem_valid,
   output logic [DATA_W-1:0] o_if_mem_data,
   input  logic              i_ls_addr_valid,
   input  logic              i_ls_we,
   input  logic [ADDR_W-1:0] i_ls_addr,
   input  logic [DATA_W-1:0] i_ls_wdata,
   output logic              o_ls_mem_valid,
   output logic [DATA_W-1:0] o_ls_mem_data,
   output logic              o_mem_addr_valid,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic              i_mem_valid,
   input  logic [DATA_W-1:0] i_mem_data,
   output logic              o_busy,
   output logic              o_timeout
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GNT_IF,
      S_GNT_LS
   } state_t;

   localparam logic [7:0] LP_STARVE = 8'(STARVE_LIMIT);
   localparam logic [7:0] LP_TMO    = 8'(TIMEOUT);

   state_t            r_state;
   state_t            w_next;
   logic              w_gnt_if;
   logic              w_gnt_ls;
   logic [ADDR_W-1:0] r_addr;
   logic              r_we;
   logic [DATA_W-1:0] r_wdata;
   logic [7:0]        r_starve;
   logic [7:0]        r_wait;
   logic [7:0]        w_wait_nxt;
   logic              r_timeout;

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Arbitration and next-state; grants only leave IDLE, responses return to it
   always_comb begin
      w_next   = r_state;
      w_gnt_if = 1'b0;
      w_gnt_ls = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (i_ls_addr_valid &&
                (!i_if_addr_valid || r_starve != LP_STARVE)) begin
               w_gnt_ls = 1'b1;
               w_next   = S_GNT_LS;
            end else if (i_if_addr_valid) begin
               w_gnt_if = 1'b1;
               w_next   = S_GNT_IF;
            end
         end
         S_GNT_IF, S_GNT_LS: begin
            if (i_mem_valid) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Saturating watchdog increment; o_timeout rises together with wait == TIMEOUT
   always_comb begin
      w_wait_nxt = r_wait;
      if (r_wait != LP_TMO) w_wait_nxt = r_wait + 8'd1;
   end

   // Latched request, starvation counter and watchdog
   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr    <= '0;
         r_we      <= 1'b0;
         r_wdata   <= '0;
         r_starve  <= '0;
         r_wait    <= '0;
         r_timeout <= 1'b0;
      end else if (w_gnt_if) begin
         r_addr   <= i_if_addr;
         r_we     <= 1'b0;
         r_wdata  <= '0;
         r_wait   <= '0;
         r_starve <= '0;
      end else if (w_gnt_ls) begin
         r_addr  <= i_ls_addr;
         r_we    <= i_ls_we;
         r_wdata <= i_ls_we ? i_ls_wdata : '0;
         r_wait  <= '0;
         if (!i_if_addr_valid)
            r_starve <= '0;
         else if (r_starve != LP_STARVE)
            r_starve <= r_starve + 8'd1;
      end else if (r_state != S_IDLE) begin
         if (i_mem_valid) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
         end else begin
            r_wait <= w_wait_nxt;
            if (w_wait_nxt == LP_TMO) r_timeout <= 1'b1;
         end
      end
   end

   // Responses pass straight through to the granted port only
   always_comb begin
      o_if_mem_valid = 1'b0;
      o_if_mem_data  = '0;
      o_ls_mem_valid = 1'b0;
      o_ls_mem_data  = '0;
      if (r_state == S_GNT_IF && i_mem_valid) begin
         o_if_mem_valid = 1'b1;
         o_if_mem_data  = i_mem_data;
      end
      if (r_state == S_GNT_LS && i_mem_valid) begin
         o_ls_mem_valid = 1'b1;
         o_ls_mem_data  = i_mem_data;
      end
   end

   assign o_mem_addr_valid = (r_state != S_IDLE);
   assign o_busy           = (r_state != S_IDLE);
   assign o_mem_we         = r_we;
   assign o_mem_addr       = r_addr;
   assign o_mem_wdata      = r_wdata;
   assign o_timeout        = r_timeout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Built with STARVE_LIMIT=2 and TIMEOUT=8 so starvation and watchdog are reachable.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_if_addr_valid;
   logic [31:0] i_if_addr;
   logic        o_if_mem_valid;
   logic [31:0] o_if_mem_data;
   logic        i_ls_addr_valid;
   logic        i_ls_we;
   logic [31:0] i_ls_addr;
   logic [31:0] i_ls_wdata;
   logic        o_ls_mem_valid;
   logic [31:0] o_ls_mem_data;
   logic        o_mem_addr_valid;
   logic        o_mem_we;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic        i_mem_valid;
   logic [31:0] i_mem_data;
   logic        o_busy;
   logic        o_timeout;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(2), .TIMEOUT(8)
   ) dut (
      .clk(clk), .reset(reset),
      .i_if_addr_valid(i_if_addr_valid), .i_if_addr(i_if_addr),
      .o_if_mem_valid(o_if_mem_valid), .o_if_mem_data(o_if_mem_data),
      .i_ls_addr_valid(i_ls_addr_valid), .i_ls_we(i_ls_we),
      .i_ls_addr(i_ls_addr), .i_ls_wdata(i_ls_wdata),
      .o_ls_mem_valid(o_ls_mem_valid), .o_ls_mem_data(o_ls_mem_data),
      .o_mem_addr_valid(o_mem_addr_valid), .o_mem_we(o_mem_we),
      .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
      .i_mem_valid(i_mem_valid), .i_mem_data(i_mem_data),
      .o_busy(o_busy), .o_timeout(o_timeout)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Entered in a grant cycle: checks latched request, answers, checks
   // the strobe routing, then lets the requester drop and checks IDLE.
   task automatic serve(input string tag, input logic ls,
                        input logic [31:0] a, input logic we,
                        input logic [31:0] wd, input logic [31:0] rd);
      chk({tag, ".av"}, 64'(o_mem_addr_valid), 64'd1);
      chk({tag, ".addr"}, 64'(o_mem_addr), 64'(a));
      chk({tag, ".we"}, 64'(o_mem_we), 64'(we));
      chk({tag, ".wdata"}, 64'(o_mem_wdata), 64'(wd));
      chk({tag, ".busy"}, 64'(o_busy), 64'd1);
      i_mem_valid = 1'b1;
      i_mem_data  = rd;
      #1;
      chk({tag, ".ls_v"}, 64'(o_ls_mem_valid), 64'(ls));
      chk({tag, ".ls_d"}, 64'(o_ls_mem_data), ls ? 64'(rd) : 64'd0);
      chk({tag, ".if_v"}, 64'(o_if_mem_valid), 64'(!ls));
      chk({tag, ".if_d"}, 64'(o_if_mem_data), ls ? 64'd0 : 64'(rd));
      tick();
      i_mem_valid = 1'b0;
      i_mem_data  = '0;
      if (ls) i_ls_addr_valid = 1'b0;
      else    i_if_addr_valid = 1'b0;
      #1;
      chk({tag, ".idle_busy"}, 64'(o_busy), 64'd0);
      chk({tag, ".idle_av"}, 64'(o_mem_addr_valid), 64'd0);
      chk({tag, ".idle_addr"}, 64'(o_mem_addr), 64'd0);
      chk({tag, ".idle_wdata"}, 64'(o_mem_wdata), 64'd0);
      chk({tag, ".idle_str"},
          64'({o_if_mem_valid, o_ls_mem_valid}), 64'd0);
   endtask

   initial begin
      reset           = 1'b1;
      i_if_addr_valid = 1'b0;
      i_if_addr       = '0;
      i_ls_addr_valid = 1'b0;
      i_ls_we         = 1'b0;
      i_ls_addr       = '0;
      i_ls_wdata      = '0;
      i_mem_valid     = 1'b0;
      i_mem_data      = '0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("rst.av", 64'(o_mem_addr_valid), 64'd0);
      chk("rst.busy", 64'(o_busy), 64'd0);
      chk("rst.tmo", 64'(o_timeout), 64'd0);
      chk("rst.addr", 64'(o_mem_addr), 64'd0);
      chk("rst.str", 64'({o_if_mem_valid, o_ls_mem_valid}), 64'd0);

      // 1: single IF read, memory answers in the third grant cycle
      i_if_addr_valid = 1'b1;
      i_if_addr       = 32'h0;
      tick();
      chk("t1.av", 64'(o_mem_addr_valid), 64'd1);
      chk("t1.ls_v", 64'(o_ls_mem_valid), 64'd0);
      tick();
      tick();
      serve("t1", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_1000);

      // 2: simultaneous IF and LS read, LS first
      i_if_addr_valid = 1'b1;
      i_if_addr       = 32'h4;
      i_ls_addr_valid = 1'b1;
      i_ls_addr       = 32'h100;
      tick();
      serve("t2ls", 1'b1, 32'h100, 1'b0, 32'h0, 32'hAAAA_0001);
      tick();
      serve("t2if", 1'b0, 32'h4, 1'b0, 32'h0, 32'hBBBB_0002);

      // 3: starvation, order LS, LS, IF, LS
      i_if_addr_valid = 1'b1;
      i_if_addr       = 32'h8;
      i_ls_addr_valid = 1'b1;
      i_ls_addr       = 32'h300;
      tick();
      serve("t3a", 1'b1, 32'h300, 1'b0, 32'h0, 32'h3);
      i_ls_addr_valid = 1'b1;
      tick();
      serve("t3b", 1'b1, 32'h300, 1'b0, 32'h0, 32'h4);
      i_ls_addr_valid = 1'b1;
      tick();
      serve("t3c", 1'b0, 32'h8, 1'b0, 32'h0, 32'h5);
      tick();
      serve("t3d", 1'b1, 32'h300, 1'b0, 32'h0, 32'h6);

      // 4: LS write, requester inputs change mid-grant
      i_ls_addr_valid = 1'b1;
      i_ls_we         = 1'b1;
      i_ls_addr       = 32'h200;
      i_ls_wdata      = 32'hDEAD_BEEF;
      tick();
      chk("t4.we", 64'(o_mem_we), 64'd1);
      chk("t4.wd", 64'(o_mem_wdata), 64'hDEAD_BEEF);
      i_ls_we    = 1'b0;
      i_ls_addr  = 32'h999;
      i_ls_wdata = 32'h1234_5678;
      tick();
      serve("t4", 1'b1, 32'h200, 1'b1, 32'hDEAD_BEEF, 32'h0);

      // 5: watchdog with silent memory
      i_if_addr_valid = 1'b1;
      i_if_addr       = 32'h40;
      tick();
      repeat (7) tick();
      chk("t5.tmo_g8", 64'(o_timeout), 64'd0);
      tick();
      chk("t5.tmo_g9", 64'(o_timeout), 64'd1);
      chk("t5.av_g9", 64'(o_mem_addr_valid), 64'd1);
      serve("t5", 1'b0, 32'h40, 1'b0, 32'h0, 32'h77);
      tick();
      chk("t5.tmo_sticky", 64'(o_timeout), 64'd1);

      // 6: reset during an IF grant, late response dropped
      i_if_addr_valid = 1'b1;
      i_if_addr       = 32'h80;
      tick();
      chk("t6.addr", 64'(o_mem_addr), 64'h80);
      reset = 1'b1;
      tick();
      reset           = 1'b0;
      i_if_addr_valid = 1'b0;
      #1;
      chk("t6.av", 64'(o_mem_addr_valid), 64'd0);
      chk("t6.addr0", 64'(o_mem_addr), 64'd0);
      chk("t6.tmo", 64'(o_timeout), 64'd0);
      tick();
      i_mem_valid = 1'b1;
      i_mem_data  = 32'h5555_5555;
      #1;
      chk("t6.if_v", 64'(o_if_mem_valid), 64'd0);
      chk("t6.if_d", 64'(o_if_mem_data), 64'd0);
      chk("t6.ls_v", 64'(o_ls_mem_valid), 64'd0);
      chk("t6.busy", 64'(o_busy), 64'd0);
      tick();
      i_mem_valid = 1'b0;
      i_mem_data  = '0;
      #1;
      chk("t6.idle", 64'(o_busy), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
